// File: rtl/bram_tdp_param.sv
// True dual-port single-clock block RAM with per-byte write enables,
// selectable same-port read-during-write behaviour, optional output
// register and a post-reset clear sequencer.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | writing zero to clr_cnt each cycle; ports are held off
// READY | clear finished (or skipped); both ports accept accesses
module bram_tdp_param #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4096,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = DATA_W / 8,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              a_en,
  input  logic [BE_W-1:0]   a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [BE_W-1:0]   b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              collision
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;

  logic              a_acc, b_acc;
  logic [BE_W-1:0]   a_wr, b_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] a_q, b_q;
  logic              a_v, b_v;

  // Old word with the enabled bytes replaced by new data.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign clearing = (state == CLEAR);

  // Nothing reaches the array or the pipelines until init_done is up.
  assign a_acc = a_en & init_done;
  assign b_acc = b_en & init_done;
  assign a_wr  = a_acc ? a_we : '0;
  assign b_wr  = b_acc ? b_we : '0;

  // Clear sequencer state register and address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
      // Rises together with the first READY cycle, so the clear is DEPTH cycles.
      init_done <= (state_next == READY);
    end
  end

  // Next-state: leave CLEAR after the last address is written.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_ADDR) state_next = READY;
      READY:   state_next = READY;
      default: state_next = state;
    endcase
  end

  // Memory array: clear writes, else byte writes with port A issued last so it
  // wins any byte both ports enable at the same address. No reset on contents.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_wr[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
        if (a_wr[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      end
    end
  end

  // First read stage. Cross-port reads see the pre-write word because the array
  // is read before this edge's writes land; write-first only merges own-port data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      a_v <= 1'b0;
      b_q <= '0;
      b_v <= 1'b0;
    end else begin
      a_v <= a_acc;
      b_v <= b_acc;
      if (a_acc) a_q <= (RDW_MODE != 0) ? merge_bytes(mem[a_addr], a_din, a_we) : mem[a_addr];
      if (b_acc) b_q <= (RDW_MODE != 0) ? merge_bytes(mem[b_addr], b_din, b_we) : mem[b_addr];
    end
  end

  // Collision flag, always one cycle after the offending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= a_acc & b_acc & (a_addr == b_addr) & ((|a_we) | (|b_we));
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] a_q2, b_q2;
      logic              a_v2, b_v2;

      // Second stage; data only advances with a valid word so dout holds otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q2 <= '0;
          a_v2 <= 1'b0;
          b_q2 <= '0;
          b_v2 <= 1'b0;
        end else begin
          a_v2 <= a_v;
          b_v2 <= b_v;
          if (a_v) a_q2 <= a_q;
          if (b_v) b_q2 <= b_q;
        end
      end

      assign a_dout  = a_q2;
      assign a_valid = a_v2;
      assign b_dout  = b_q2;
      assign b_valid = b_v2;
    end else begin : g_no_out_reg
      assign a_dout  = a_q;
      assign a_valid = a_v;
      assign b_dout  = b_q;
      assign b_valid = b_v;
    end
  endgenerate

endmodule

// File: tb/tb_bram_tdp_param.sv
// Directed bench: three instances share one stimulus stream.
// d0: read-first, latency 1, clear on reset
// d1: write-first, latency 2, clear on reset
// d2: no clear (only init_done timing is observed)
module tb_bram_tdp_param;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int BW = DW / 8;
  localparam int AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_en = 1'b0, b_en = 1'b0;
  logic [BW-1:0] a_we = '0, b_we = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;

  logic          d0_init, d0_av, d0_bv, d0_col;
  logic [DW-1:0] d0_ad, d0_bd;
  logic          d1_init, d1_av, d1_bv, d1_col;
  logic [DW-1:0] d1_ad, d1_bd;
  logic          d2_init, d2_av, d2_bv, d2_col;
  logic [DW-1:0] d2_ad, d2_bd;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bram_tdp_param #(.DATA_W(DW), .DEPTH(DP), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) d0 (
    .clk(clk), .rst_n(rst_n), .init_done(d0_init),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(d0_ad), .a_valid(d0_av),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(d0_bd), .b_valid(d0_bv),
    .collision(d0_col));

  bram_tdp_param #(.DATA_W(DW), .DEPTH(DP), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) d1 (
    .clk(clk), .rst_n(rst_n), .init_done(d1_init),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(d1_ad), .a_valid(d1_av),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(d1_bd), .b_valid(d1_bv),
    .collision(d1_col));

  bram_tdp_param #(.DATA_W(DW), .DEPTH(DP), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) d2 (
    .clk(clk), .rst_n(rst_n), .init_done(d2_init),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(d2_ad), .a_valid(d2_av),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(d2_bd), .b_valid(d2_bv),
    .collision(d2_col));

  typedef struct {
    logic          a_en;
    logic [BW-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          b_en;
    logic [BW-1:0] b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic [DW-1:0] a0;   // d0 (read-first) port A data
    logic [DW-1:0] a1;   // d1 (write-first) port A data
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic          col;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  // One request cycle, then one idle cycle: d0 checked at +1, d1 at +2.
  task automatic apply(input vec_t v, input int idx);
    a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
    b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
    step();
    chk($sformatf("v%0d_d0_a_valid", idx), d0_av, v.a_en);
    if (v.a_en) chk($sformatf("v%0d_d0_a_dout", idx), d0_ad, v.a0);
    chk($sformatf("v%0d_d0_b_valid", idx), d0_bv, v.b_en);
    if (v.b_en) chk($sformatf("v%0d_d0_b_dout", idx), d0_bd, v.b0);
    chk($sformatf("v%0d_d0_collision", idx), d0_col, v.col);
    chk($sformatf("v%0d_d1_collision", idx), d1_col, v.col);
    idle();
    step();
    chk($sformatf("v%0d_d1_a_valid", idx), d1_av, v.a_en);
    if (v.a_en) chk($sformatf("v%0d_d1_a_dout", idx), d1_ad, v.a1);
    chk($sformatf("v%0d_d1_b_valid", idx), d1_bv, v.b_en);
    if (v.b_en) chk($sformatf("v%0d_d1_b_dout", idx), d1_bd, v.b1);
    if (v.a_en) chk($sformatf("v%0d_d0_a_hold", idx), d0_ad, v.a0);
  endtask

  initial begin
    logic [DW-1:0] mdl [DP];
    logic [DW-1:0] exq [DP];
    int t0, t1;

    tv[0]  = '{1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 4'h0, 4'd15, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0,  32'h0,
               32'h0, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0};
    tv[2]  = '{1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0,  32'h0,
               32'hAABBCCDD, 32'hAA22CC44, 32'h0, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 4'h0, 4'd3,  32'h0,
               32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
    tv[4]  = '{1'b1, 4'hF, 4'd7, 32'h1,        1'b0, 4'h0, 4'd0,  32'h0,
               32'h0, 32'h1, 32'h0, 32'h0, 1'b0};
    tv[5]  = '{1'b1, 4'hF, 4'd7, 32'h2,        1'b1, 4'h0, 4'd7,  32'h0,
               32'h1, 32'h2, 32'h1, 32'h1, 1'b1};
    tv[6]  = '{1'b1, 4'hC, 4'd9, 32'hFFFF0000, 1'b1, 4'h6, 4'd9,  32'h12345678,
               32'h0, 32'hFFFF0000, 32'h0, 32'h00345600, 1'b1};
    tv[7]  = '{1'b1, 4'h0, 4'd9, 32'h0,        1'b1, 4'h0, 4'd9,  32'h0,
               32'hFFFF5600, 32'hFFFF5600, 32'hFFFF5600, 32'hFFFF5600, 1'b0};
    tv[8]  = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 4'h1, 4'd7,  32'h000000EE,
               32'h2, 32'h2, 32'h2, 32'h000000EE, 1'b1};
    tv[9]  = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 4'hF, 4'd8,  32'h5,
               32'hEE, 32'hEE, 32'h0, 32'h5, 1'b0};
    tv[10] = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b0, 4'hF, 4'd7,  32'hFFFFFFFF,
               32'hEE, 32'hEE, 32'h0, 32'h0, 1'b0};
    tv[11] = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 4'h0, 4'd8,  32'h0,
               32'hEE, 32'hEE, 32'h5, 32'h5, 1'b0};
    tv[12] = '{1'b1, 4'h0, 4'd9, 32'hDEADBEEF, 1'b1, 4'h0, 4'd3,  32'h0,
               32'hFFFF5600, 32'hFFFF5600, 32'hAA22CC44, 32'hAA22CC44, 1'b0};

    // Reset values
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d0_init", d0_init, 1'b0);
    chk("rst_d1_init", d1_init, 1'b0);
    chk("rst_d2_init", d2_init, 1'b0);
    chk("rst_d0_a_dout", d0_ad, 32'h0);
    chk("rst_d1_b_dout", d1_bd, 32'h0);
    chk("rst_d0_valid", {d0_av, d0_bv}, 2'b00);
    chk("rst_d1_valid", {d1_av, d1_bv}, 2'b00);
    chk("rst_collision", {d0_col, d1_col}, 2'b00);

    // Clear sequence: count edges until init_done; a request at cycle 5 is ignored
    @(negedge clk);
    rst_n = 1'b1;
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) chk("d2_init_first_edge", d2_init, 1'b1);
      if (k == 4) begin
        a_en = 1'b1; a_we = 4'hF; a_addr = 4'd0; a_din = 32'hDEADBEEF;
        b_en = 1'b1; b_we = 4'hF; b_addr = 4'd0; b_din = 32'h12345678;
      end
      if (k == 5) begin
        chk("clr_req_a_valid", d0_av, 1'b0);
        chk("clr_req_b_valid", d0_bv, 1'b0);
        chk("clr_req_collision", d0_col, 1'b0);
        idle();
      end
      if (d0_init && t0 == 0) t0 = k;
      if (d1_init && t1 == 0) t1 = k;
      if (t0 != 0 && t1 != 0) break;
    end
    chk("clr_d0_cycles", t0, 16);
    chk("clr_d1_cycles", t1, 16);

    // Read back every address as a back-to-back stream
    for (int i = 0; i < DP; i++) begin
      a_en = 1'b1; a_addr = AW'(i);
      step();
      chk($sformatf("clr_rd%0d_valid", i), d0_av, 1'b1);
      chk($sformatf("clr_rd%0d_dout", i), d0_ad, 32'h0);
    end
    idle();
    step();

    // Table vectors
    for (int i = 0; i < 13; i++) apply(tv[i], i);

    // Throughput: preload via B, then A streams reads while B streams writes
    for (int k = 0; k < DP; k++) begin
      b_en = 1'b1; b_we = 4'hF; b_addr = AW'(k); b_din = 32'h1000_0000 + k;
      mdl[k] = 32'h1000_0000 + k;
      step();
    end
    idle();
    step();
    for (int i = 0; i <= DP; i++) begin
      if (i < DP) begin
        a_en = 1'b1; a_we = '0; a_addr = AW'(i);
        b_en = 1'b1; b_we = 4'hF; b_addr = AW'(DP - 1 - i); b_din = 32'h5A00_0000 + i;
        exq[i] = mdl[i];
        mdl[DP - 1 - i] = 32'h5A00_0000 + i;
      end else begin
        idle();
      end
      step();
      if (i < DP) begin
        chk($sformatf("tp%0d_d0_a_valid", i), d0_av, 1'b1);
        chk($sformatf("tp%0d_d0_a_dout", i), d0_ad, exq[i]);
        chk($sformatf("tp%0d_collision", i), d0_col, 1'b0);
      end
      if (i >= 1) begin
        chk($sformatf("tp%0d_d1_a_valid", i - 1), d1_av, 1'b1);
        chk($sformatf("tp%0d_d1_a_dout", i - 1), d1_ad, exq[i - 1]);
      end
    end
    idle();
    step();

    // Mid-operation reset during an OUT_REG=1 read stream
    for (int k = 0; k < 4; k++) begin
      a_en = 1'b1; a_addr = AW'(k);
      step();
    end
    chk("mid_d1_valid_before", d1_av, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_d1_valid_drop", d1_av, 1'b0);
    chk("mid_d1_dout_clr", d1_ad, 32'h0);
    chk("mid_d1_init", d1_init, 1'b0);
    chk("mid_d0_valid_drop", d0_av, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t1 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (d1_init) begin
        t1 = k;
        break;
      end
    end
    chk("mid_reclear_cycles", t1, 16);

    // Memory was cleared again by the restarted sequence
    a_en = 1'b1; a_addr = 4'd3;
    step();
    chk("post_d0_rd3", d0_ad, 32'h0);
    idle();
    step();
    chk("post_d1_rd3_valid", d1_av, 1'b1);
    chk("post_d1_rd3", d1_ad, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bram_tdp_param.md
# bram_tdp_param

Parametrised single-clock true dual-port block RAM with per-byte write enables, a selectable read-during-write mode, an optional output register stage and a post-reset clear sequencer. It replaces fixed-size 8-bit dual-port memory shells wherever the core needs a scratch or buffer memory with two independent access ports. It also reports cross-port address collisions.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8; BE_W = DATA_W/8
- DEPTH, 4096, number of words; ADDR_W = $clog2(DEPTH)
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged word)
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting accesses
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- init_done  output  1  memory ready; accesses are ignored while 0
- a_en  input  1  port A access request
- a_we  input  BE_W  port A byte write enables; bit i covers a_din[8i+7:8i]
- a_addr  input  ADDR_W  port A word address
- a_din  input  DATA_W  port A write data
- a_dout  output  DATA_W  port A read data
- a_valid  output  1  a_dout carries data for a request OUT_REG+1 cycles earlier
- b_en, b_we, b_addr, b_din, b_dout, b_valid: port B, identical to port A
- collision  output  1  one-cycle pulse: same-address cross-port access with at least one write

## Operation
- Clear FSM states: CLEAR, READY.
- rst_n low forces CLEAR with clear counter 0 if CLEAR_ON_RESET=1, else READY.
- CLEAR: writes zero to address counter each cycle. Counter == DEPTH-1 -> READY. Clear takes exactly DEPTH cycles.
- READY is terminal until the next reset.
- init_done is registered high on the first cycle in READY. With CLEAR_ON_RESET=0 it rises on the first clk edge after rst_n deasserts.
- While init_done=0, a_en/b_en are ignored: no write, no valid, no collision.
- Access: en=1 reads the word at addr. Bytes with we[i]=1 are written.
- we=0 with en=1 is a pure read. en=0 ignores we.
- Same-port read-during-write follows RDW_MODE. Write-first returns old bytes where we=0 and new bytes where we=1.
- Cross-port, same address, both writing: per byte, port A wins where both enable. B's bytes are written where only B enables.
- Cross-port read of an address the other port writes in the same cycle always returns the old word.
- collision is asserted one cycle after a_en & b_en & (a_addr==b_addr) & (|a_we | |b_we), inside READY.
- dout holds its last value while valid=0.
- Memory contents are not reset; only the clear sequence zeroes them.

## Timing
- Reset values: init_done=0, a_dout=b_dout=0, a_valid=b_valid=0, collision=0, pipeline registers 0.
- OUT_REG=0: request at edge N -> dout/valid at edge N+1. OUT_REG=1: at edge N+2.
- Back-to-back requests every cycle are supported on both ports; full throughput, no stalls.
- Write visible to either port's read issued in the next cycle or later.
- Reset asserted mid-operation: outputs and valid pipeline clear immediately (asynchronous). In-flight reads are dropped. The FSM restarts CLEAR from address 0 after release.
- collision latency is fixed at 1 cycle regardless of OUT_REG.

## Test plan
Bench configuration: DATA_W=32, DEPTH=16.
- Clear: CLEAR_ON_RESET=1, release reset -> init_done rises after exactly 16 cycles. Reads of all addresses return 0x00000000. A request issued at cycle 5 produces no valid.
- Byte write: write 0xAABBCCDD at address 3 with we=4'hF, then we=4'b0101 with din 0x11223344 -> read returns 0xAA22CC44 with latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- RDW: address 7 holds 0x1; port A writes 0x2 with a read in the same cycle -> a_dout=0x1 with RDW_MODE=0 and 0x2 with RDW_MODE=1. Port B reading 7 in the same cycle gets 0x1 in both modes.
- Collision: A writes 0xFFFF0000 (we=4'b1100), B writes 0x12345678 (we=4'b0110), both at address 9 -> collision pulses 1 cycle. Readback returns 0xFFFF5600 (bytes 3 and 2 from A, byte 1 from B, byte 0 untouched at 00 after clear).
- Throughput: stream 16 consecutive reads on A and writes on B (different addresses) -> 16 consecutive a_valid cycles, correct data, collision never asserted.
- Mid-op reset: pull rst_n low during a streaming read with OUT_REG=1 -> valid drops the same cycle. init_done=0, then re-rises 16 cycles after release.
